// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_flt_pkg.sv
// Shared definitions for the filtered multi-channel NOR: parameter limits,
// counter width helper and the per-channel state record.
package gf180mcu_fd_sc_mcu9t5v0__nor_flt_pkg;

    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 16;
    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 8;
    localparam int FILT_MIN     = 1;
    localparam int FILT_MAX     = 255;

    // Wide enough for the largest legal FILT_CYC; each channel uses the low CW bits.
    localparam int CNT_MAX_W    = 8;

    function automatic int cw_f(input int filt_cyc);
        return $clog2(filt_cyc + 1);
    endfunction

    typedef struct packed {
        logic                 zn;
        logic [CNT_MAX_W-1:0] cnt;
    } chan_state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_flt_chan.sv
// One filtered NOR channel: ZN follows ~|A only after FILT_CYC consecutive
// disagreeing edges; CHG pulses for the cycle in which a new ZN appears.
module gf180mcu_fd_sc_mcu9t5v0__nor_flt_chan
    import gf180mcu_fd_sc_mcu9t5v0__nor_flt_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int FILT_CYC = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             HOLD,
    input  logic [WIDTH-1:0] A,
    output logic             ZN,
    output logic             CHG
);

    localparam int                   CW      = cw_f(FILT_CYC);
    localparam logic [CW-1:0]        TERM_CW = CW'(FILT_CYC - 1);
    localparam logic [CNT_MAX_W-1:0] TERM    = CNT_MAX_W'(TERM_CW);

    logic        w_raw;
    chan_state_t r_st;
    chan_state_t w_nxt;
    logic        r_chg;
    logic        w_chg_nxt;

    assign w_raw = ~|A;

    // HOLD wins over a toggle that would otherwise complete on this edge.
    always_comb begin
        w_nxt     = r_st;
        w_chg_nxt = 1'b0;
        if (!HOLD) begin
            if (w_raw == r_st.zn) begin
                w_nxt.cnt = '0;
            end else if (r_st.cnt == TERM) begin
                w_nxt.zn  = w_raw;
                w_nxt.cnt = '0;
                w_chg_nxt = 1'b1;
            end else begin
                w_nxt.cnt = r_st.cnt + CNT_MAX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_st  <= '0;
            r_chg <= 1'b0;
        end else begin
            r_st  <= w_nxt;
            r_chg <= w_chg_nxt;
        end
    end

    assign ZN  = r_st.zn;
    assign CHG = r_chg;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv
// Multi-channel registered NOR with per-channel glitch filter.
// Define GF180MCU_FD_SC_MCU9T5V0_NOR_FLT_SYNC_EN to add a two-flop input synchroniser.
module gf180mcu_fd_sc_mcu9t5v0__nor_flt
    import gf180mcu_fd_sc_mcu9t5v0__nor_flt_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 3,
    parameter int FILT_CYC = 4
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      HOLD,
    output logic [CHANNELS-1:0]       ZN,
    output logic [CHANNELS-1:0]       CHG
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $fatal(1, "nor_flt: CHANNELS=%0d out of range", CHANNELS);
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "nor_flt: WIDTH=%0d out of range", WIDTH);
    end
    if (FILT_CYC < FILT_MIN || FILT_CYC > FILT_MAX) begin : g_bad_filt
        $fatal(1, "nor_flt: FILT_CYC=%0d out of range", FILT_CYC);
    end

    logic [CHANNELS*WIDTH-1:0] w_a;

`ifdef GF180MCU_FD_SC_MCU9T5V0_NOR_FLT_SYNC_EN
    logic [CHANNELS*WIDTH-1:0] r_sync_p0;
    logic [CHANNELS*WIDTH-1:0] r_sync_p1;

    // Synchroniser keeps running under HOLD; only channel state is frozen.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= A;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_a = r_sync_p1;
`else
    assign w_a = A;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        gf180mcu_fd_sc_mcu9t5v0__nor_flt_chan #(
            .WIDTH    (WIDTH),
            .FILT_CYC (FILT_CYC)
        ) u_chan (
            .CLK  (CLK),
            .RN   (RN),
            .HOLD (HOLD),
            .A    (w_a[c*WIDTH +: WIDTH]),
            .ZN   (ZN[c]),
            .CHG  (CHG[c])
        );
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv
// Bench for the filtered NOR: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a streak-count model.
module tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt;

    localparam int CH   = 2;
    localparam int W    = 3;
    localparam int FILT = 4;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NOR_FLT_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic            CLK;
    logic            RN;
    logic            HOLD;
    logic [CH*W-1:0] A;
    logic [CH-1:0]   ZN;
    logic [CH-1:0]   CHG;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    gf180mcu_fd_sc_mcu9t5v0__nor_flt #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .FILT_CYC (FILT)
    ) dut (
        .CLK  (CLK),
        .RN   (RN),
        .A    (A),
        .HOLD (HOLD),
        .ZN   (ZN),
        .CHG  (CHG)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: ZN flips once the raw NOR has differed from it on
    // FILT consecutive non-held edges; any agreement or reset restarts the streak.
    logic [CH-1:0]   m_zn  = '0;
    logic [CH-1:0]   m_chg = '0;
    int              m_run [CH];
    logic [CH*W-1:0] m_s1  = '0;
    logic [CH*W-1:0] m_s2  = '0;

    initial for (int i = 0; i < CH; i++) m_run[i] = 0;

    always @(posedge CLK) begin
        logic [CH*W-1:0] a_eff;
        logic            raw;
        a_eff = (SD != 0) ? m_s2 : A;
        for (int c = 0; c < CH; c++) begin
            raw = (a_eff[c*W +: W] == '0);
            if (!RN) begin
                m_zn[c] = 0; m_chg[c] = 0; m_run[c] = 0;
            end else if (HOLD) begin
                m_chg[c] = 0;
            end else if (raw == m_zn[c]) begin
                m_run[c] = 0; m_chg[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
                m_chg[c] = 0;
                if (m_run[c] == FILT) begin
                    m_zn[c] = raw; m_run[c] = 0; m_chg[c] = 1;
                end
            end
        end
        if (!RN) begin
            m_s1 = '0; m_s2 = '0;
        end else begin
            m_s2 = m_s1; m_s1 = A;
        end
    end

    task automatic check(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [CH-1:0] ezn, input logic [CH-1:0] echg);
        check({nm, "_zn"}, ZN, ezn);
        check({nm, "_chg"}, CHG, echg);
        check({nm, "_model_zn"}, m_zn, ezn);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_zn", ZN, m_zn);
            check("cyc_chg", CHG, m_chg);
        end
    end

    initial begin
        RN = 0; HOLD = 0; A = '0;
        tick(2);
        lit("reset", 2'b00, 2'b00);
        chk_en = 1;

        RN = 1;
        tick(3);
        lit("rel_wait", 2'b00, 2'b00);
        tick(1);
        lit("rel_rise", 2'b11, 2'b11);
        tick(1);
        lit("rel_after", 2'b11, 2'b00);

        // 3-cycle glitch on channel 0 is rejected
        A = 6'b000_001;
        tick(3);
        A = '0;
        tick(4 + SD);
        lit("glitch3", 2'b11, 2'b00);

        // 4-cycle pulse passes
        A = 6'b000_001;
        tick(4);
        A = '0;
        tick(SD);
        lit("pulse4", 2'b10, 2'b01);
        tick(1);
        lit("pulse4_end", 2'b10, 2'b00);
        tick(8);
        lit("pulse4_back", 2'b11, 2'b00);

        // HOLD on the completing edge, then release
        A = 6'b010_000;
        tick(3 + SD);
        HOLD = 1;
        tick(1);
        lit("hold_edge", 2'b11, 2'b00);
        tick(2);
        lit("hold_frozen", 2'b11, 2'b00);
        HOLD = 0;
        tick(1);
        lit("hold_release", 2'b01, 2'b10);
        A = '0;
        tick(8);
        lit("hold_back", 2'b11, 2'b00);

        // Reset in the middle of a filter run
        A = 6'b000_001;
        tick(2 + SD);
        RN = 0;
        tick(1);
        lit("mid_rst", 2'b00, 2'b00);
        RN = 1;
        tick(3);
        lit("mid_rst_wait", 2'b00, 2'b00);
        tick(1);
        lit("mid_rst_rise", 2'b10, 2'b10);

        // Channel independence
        A = '0;
        tick(8);
        lit("indep_pre", 2'b11, 2'b00);
        A = 6'b000_001;
        tick(4 + SD);
        lit("indep", 2'b10, 2'b01);

        // Randomized traffic: slowly changing inputs, occasional HOLD and reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) A = 6'($urandom) & 6'($urandom);
            HOLD = ($urandom_range(0, 9) == 0);
            RN   = ($urandom_range(0, 59) != 0);
            tick(1);
        end
        RN = 1; HOLD = 0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
